poly_to_msg: RTL

POLY_TO_MSG -- requirements
Module: poly_to_msg

---
 rtl/kyber_pkg.sv | 21 ++
 rtl/compress1_bit.sv | 16 +
 rtl/poly_to_msg.sv | 120 ++++++++++++
 3 files changed

// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the message-recovery FSM state type.
// Provides:
//   KYBER_N        polynomial length (message bits)
//   KYBER_Q        modulus
//   KYBER_R_WIDTH  coefficient width
//   COMPRESS1_LO / COMPRESS1_HI  inclusive window that decodes to a 1 bit
//   p2m_state_t    COLLECT / OUTPUT states of poly_to_msg
package kyber_pkg;

  localparam int KYBER_N       = 256;
  localparam int KYBER_Q       = 3329;
  localparam int KYBER_R_WIDTH = 12;
  localparam int COMPRESS1_LO  = 833;
  localparam int COMPRESS1_HI  = 2496;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } p2m_state_t;

endpackage

// File: rtl/compress1_bit.sv
// Kyber Compress_q(x,1) for one coefficient: 1 when x lies in
// [COMPRESS1_LO, COMPRESS1_HI], otherwise 0. Purely combinational.
// Ports:
//   coeff    in   12-bit unsigned coefficient
//   msg_bit  out  decoded message bit
module compress1_bit
  import kyber_pkg::*;
(
  input  logic [KYBER_R_WIDTH-1:0] coeff,
  output logic                     msg_bit
);

  assign msg_bit = (coeff >= KYBER_R_WIDTH'(COMPRESS1_LO)) &&
                   (coeff <= KYBER_R_WIDTH'(COMPRESS1_HI));

endmodule

// File: rtl/poly_to_msg.sv
// Collects KYBER_N coefficients in beats of COEFFS_PER_BEAT, compresses each
// to one bit and presents the 256-bit message with a valid/ready handshake.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   clr                synchronous abort of the current message
//   coeff_in/_valid    packed beat (lane j at [12*j +: 12]) and its valid
//   coeff_ready        beat accepted this cycle when valid is also high
//   msg/msg_valid      recovered message, held until msg_ready
//   msg_ready          consumer takes msg
//   err                sticky out-of-range flag
// Build option: POLY_TO_MSG_RANGE_CHECK_EN compiles in the x >= q check on
// accepted lanes; without it err is tied low.
//
// state   | meaning
// COLLECT | accepting beats, msg filling up
// OUTPUT  | msg complete, waiting for msg_ready, no beats accepted
module poly_to_msg
  import kyber_pkg::*;
#(
  parameter int COEFFS_PER_BEAT = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clr,
  input  logic [COEFFS_PER_BEAT*KYBER_R_WIDTH-1:0] coeff_in,
  input  logic                                     coeff_valid,
  output logic                                     coeff_ready,
  output logic [KYBER_N-1:0]                       msg,
  output logic                                     msg_valid,
  input  logic                                     msg_ready,
  output logic                                     err
);

  localparam int BEATS  = KYBER_N / COEFFS_PER_BEAT;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int MSG_AW = $clog2(KYBER_N);

  p2m_state_t                 state;
  logic [CNT_W-1:0]           beat_cnt;
  logic [COEFFS_PER_BEAT-1:0] lane_bits;
  logic [MSG_AW-1:0]          base;
  logic                       accept;
  logic                       last_beat;

  for (genvar j = 0; j < COEFFS_PER_BEAT; j++) begin : g_lane
    compress1_bit u_bit (
      .coeff   (coeff_in[KYBER_R_WIDTH*j +: KYBER_R_WIDTH]),
      .msg_bit (lane_bits[j])
    );
  end

  // Gated by rst_n so every output reads 0 while reset is held.
  assign coeff_ready = rst_n && (state == COLLECT);
  assign accept      = coeff_valid && coeff_ready;
  assign last_beat   = (beat_cnt == CNT_W'(BEATS - 1));
  assign base        = MSG_AW'(int'(beat_cnt) * COEFFS_PER_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      beat_cnt  <= '0;
      msg       <= '0;
      msg_valid <= 1'b0;
    end else if (clr) begin
      state     <= COLLECT;
      beat_cnt  <= '0;
      msg       <= '0;
      msg_valid <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            msg[base +: COEFFS_PER_BEAT] <= lane_bits;
            // BEATS is a power of two, so the counter wraps to 0 on the last beat.
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              state     <= OUTPUT;
              msg_valid <= 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (msg_ready) begin
            state     <= COLLECT;
            beat_cnt  <= '0;
            msg       <= '0;
            msg_valid <= 1'b0;
          end
        end
        default: begin
          state     <= COLLECT;
          beat_cnt  <= '0;
          msg       <= '0;
          msg_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef POLY_TO_MSG_RANGE_CHECK_EN
  logic [COEFFS_PER_BEAT-1:0] lane_oor;

  for (genvar j = 0; j < COEFFS_PER_BEAT; j++) begin : g_oor
    assign lane_oor[j] = coeff_in[KYBER_R_WIDTH*j +: KYBER_R_WIDTH] >= KYBER_R_WIDTH'(KYBER_Q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (accept && (|lane_oor)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
